// File: rtl/seg7_scan_sequencer.sv
// Serialises a captured result word onto one 7-segment digit, MS nibble first, then a blank gap.
// Optional macro SEG7_SCAN_BLINK_EN adds a 'blink' input that darkens the second half of each nibble.
module seg7_scan_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DWELL_CYCLES = 1000000,
  localparam int NDIG        = DATA_WIDTH / 4,
  localparam int IDX_W       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  run,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic                  blink,
`endif
  output logic [3:0]            nibble_out,
  output logic                  dp_out,
  output logic                  blank_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0]  DW_ZERO  = DW_W'(0);
  localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);
  localparam logic [DW_W-1:0]  DW_TERM  = DW_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MS   = IDX_W'(NDIG - 1);
`ifdef SEG7_SCAN_BLINK_EN
  localparam logic [DW_W-1:0]  DW_HALF  = DW_W'(DWELL_CYCLES / 2);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [DW_W-1:0]         dwell_r, dwell_nx_s;
  logic [IDX_W-1:0]        idx_r, idx_nx_s;
  logic [DATA_WIDTH-1:0]   pending_r, shadow_r, shadow_nx_s;
  logic                    load_s, fd_nx_s;
  logic [3:0]              nibble_r, nibble_nx_s;
  logic                    dp_r, dp_nx_s, blank_r, blank_nx_s, frame_done_r;

  // Next-state sequencing: dwell counting, digit stepping and frame reload points.
  always_comb begin
    state_nx_s = state_r;
    dwell_nx_s = dwell_r;
    idx_nx_s   = idx_r;
    load_s     = 1'b0;
    fd_nx_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nx_s = ST_SHOW;
          dwell_nx_s = DW_ZERO;
          idx_nx_s   = IDX_MS;
          load_s     = 1'b1;
        end else begin
          dwell_nx_s = DW_ZERO;
          idx_nx_s   = IDX_ZERO;
        end
      end
      ST_SHOW: begin
        if (!run) begin
          state_nx_s = ST_IDLE;
          dwell_nx_s = DW_ZERO;
          idx_nx_s   = IDX_ZERO;
        end else if (dwell_r == DW_TERM) begin
          dwell_nx_s = DW_ZERO;
          if (idx_r != IDX_ZERO) begin
            idx_nx_s = idx_r - IDX_ONE;
          end else begin
            state_nx_s = ST_GAP;
            fd_nx_s    = 1'b1;
          end
        end else begin
          dwell_nx_s = dwell_r + DW_ONE;
        end
      end
      ST_GAP: begin
        if (!run) begin
          state_nx_s = ST_IDLE;
          dwell_nx_s = DW_ZERO;
          idx_nx_s   = IDX_ZERO;
        end else if (dwell_r == DW_TERM) begin
          state_nx_s = ST_SHOW;
          dwell_nx_s = DW_ZERO;
          idx_nx_s   = IDX_MS;
          load_s     = 1'b1;
        end else begin
          dwell_nx_s = dwell_r + DW_ONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        dwell_nx_s = DW_ZERO;
        idx_nx_s   = IDX_ZERO;
      end
    endcase
  end

  // Frame load takes a same-cycle capture directly so the new word is never one frame late.
  always_comb begin
    shadow_nx_s = shadow_r;
    if (load_s) begin
      shadow_nx_s = data_valid ? data_in : pending_r;
    end else begin
      shadow_nx_s = shadow_r;
    end
  end

  // Output values derived from the next state so every output leaves a flop.
  always_comb begin
    blank_nx_s  = 1'b1;
    dp_nx_s     = 1'b0;
    nibble_nx_s = 4'h0;
    if (state_nx_s == ST_SHOW) begin
`ifdef SEG7_SCAN_BLINK_EN
      blank_nx_s  = blink && (dwell_nx_s >= DW_HALF);
`else
      blank_nx_s  = 1'b0;
`endif
      dp_nx_s     = (idx_nx_s == IDX_ZERO);
      nibble_nx_s = 4'(shadow_nx_s >> {idx_nx_s, 2'b00});
    end else begin
      blank_nx_s  = 1'b1;
      dp_nx_s     = 1'b0;
      nibble_nx_s = 4'h0;
    end
  end

  // State, capture registers and outputs; ena low freezes all but the frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dwell_r      <= DW_ZERO;
      idx_r        <= IDX_ZERO;
      pending_r    <= {DATA_WIDTH{1'b0}};
      shadow_r     <= {DATA_WIDTH{1'b0}};
      nibble_r     <= 4'h0;
      dp_r         <= 1'b0;
      blank_r      <= 1'b1;
      frame_done_r <= 1'b0;
    end else if (ena) begin
      state_r      <= state_nx_s;
      dwell_r      <= dwell_nx_s;
      idx_r        <= idx_nx_s;
      shadow_r     <= shadow_nx_s;
      nibble_r     <= nibble_nx_s;
      dp_r         <= dp_nx_s;
      blank_r      <= blank_nx_s;
      frame_done_r <= fd_nx_s;
      if (data_valid) begin
        pending_r <= data_in;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign nibble_out = nibble_r;
  assign dp_out     = dp_r;
  assign blank_out  = blank_r;
  assign digit_idx  = idx_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_sequencer.sv
// Self-checking bench for seg7_scan_sequencer (DATA_WIDTH=8, DWELL_CYCLES=4): directed literal
// checks plus randomized traffic compared every cycle against a frame-position model.
module tb_seg7_scan_sequencer;
  localparam int DW    = 8;
  localparam int DWELL = 4;
  localparam int NDIG  = DW / 4;

  logic          clk = 1'b0;
  logic          rst, ena, run, data_valid;
  logic [DW-1:0] data_in;
  logic [3:0]    nibble_out;
  logic          dp_out, blank_out, frame_done;
  logic [0:0]    digit_idx;

  int n_total = 0;
  int n_pass  = 0;

  // model: position inside the (NDIG+1)*DWELL frame while active
  bit            m_active = 1'b0;
  int            m_pos    = 0;
  logic [DW-1:0] m_frame  = '0;
  logic [DW-1:0] m_pend   = '0;
  bit            m_fd     = 1'b0;

  seg7_scan_sequencer #(.DATA_WIDTH(DW), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .ena(ena), .run(run), .data_valid(data_valid), .data_in(data_in),
    .nibble_out(nibble_out), .dp_out(dp_out), .blank_out(blank_out),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    logic [DW-1:0] nxt_pend;
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_frame = '0; m_pend = '0; m_fd = 1'b0;
    end else if (!ena) begin
      m_fd = 1'b0;
    end else begin
      nxt_pend = data_valid ? data_in : m_pend;
      m_fd = 1'b0;
      if (!m_active) begin
        if (run) begin
          m_active = 1'b1; m_pos = 0; m_frame = nxt_pend;
        end
      end else if (!run) begin
        m_active = 1'b0; m_pos = 0;
      end else begin
        m_pos++;
        if (m_pos == (NDIG + 1) * DWELL) begin
          m_pos = 0; m_frame = nxt_pend;
        end else if (m_pos == NDIG * DWELL) begin
          m_fd = 1'b1;
        end
      end
      m_pend = nxt_pend;
    end
  endtask

  task automatic model_compare();
    bit showing;
    int idx;
    logic [DW-1:0] sh;
    showing = m_active && (m_pos < NDIG * DWELL);
    idx = showing ? (NDIG - 1 - m_pos / DWELL) : 0;
    sh = m_frame >> (4 * idx);
    chk("m_blank", blank_out, !showing);
    chk("m_frame_done", frame_done, m_fd);
    chk("m_dp", dp_out, showing && (idx == 0));
    chk("m_idx", digit_idx, idx);
    if (showing) chk("m_nibble", nibble_out, sh[3:0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
  endtask

  task automatic chk_reset_vals();
    chk("rst_blank", blank_out, 1'b1);
    chk("rst_nibble", nibble_out, 4'h0);
    chk("rst_dp", dp_out, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_idx", digit_idx, 1'b0);
  endtask

  initial begin
    logic [7:0] val;
    int ph;
    rst = 1'b1; ena = 1'b1; run = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (2) begin
      step();
      chk_reset_vals();
    end
    rst = 1'b0;

    // A5 captured with bypass on start; 3C captured while A is shown
    for (int i = 0; i < 48; i++) begin
      data_valid = (i == 0) || (i == 25);
      data_in    = (i == 0) ? 8'hA5 : 8'h3C;
      step();
      ph  = i % 12;
      val = (i < 36) ? 8'hA5 : 8'h3C;
      if (ph < 8) begin
        chk("lit_nibble", nibble_out, (ph < 4) ? val[7:4] : val[3:0]);
        chk("lit_dp", dp_out, ph >= 4);
        chk("lit_idx", digit_idx, ph < 4);
        chk("lit_blank", blank_out, 1'b0);
        chk("lit_fd_show", frame_done, 1'b0);
      end else begin
        chk("lit_gap_blank", blank_out, 1'b1);
        chk("lit_gap_fd", frame_done, ph == 8);
      end
    end
    data_valid = 1'b0;

    // freeze after the second cycle of nibble 3
    repeat (2) step();
    chk("pre_freeze_nibble", nibble_out, 4'h3);
    ena = 1'b0;
    repeat (10) begin
      step();
      chk("frz_nibble", nibble_out, 4'h3);
      chk("frz_blank", blank_out, 1'b0);
      chk("frz_idx", digit_idx, 1'b1);
    end
    ena = 1'b1;
    repeat (2) begin
      step();
      chk("post_freeze_nibble", nibble_out, 4'h3);
    end
    step();
    chk("next_nibble", nibble_out, 4'hC);
    chk("next_dp", dp_out, 1'b1);

    // run dropped mid LS nibble
    step();
    run = 1'b0;
    step();
    chk("stop_blank", blank_out, 1'b1);
    chk("stop_fd", frame_done, 1'b0);
    chk("stop_idx", digit_idx, 1'b0);
    step();
    chk("idle_blank", blank_out, 1'b1);

    // reset in the middle of a frame
    run = 1'b1;
    repeat (3) step();
    chk("restart_nibble", nibble_out, 4'h3);
    rst = 1'b1;
    step();
    chk_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) == 0);
      ena        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) run = ~run;
      data_valid = ($urandom_range(0, 5) == 0);
      data_in    = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
